// File: rtl/spi_arbiter.sv
// Round-robin arbiter that lends one SPI master to NREQ requesters, driving a
// per-requester chip select around each multi-frame transaction.
module spi_arbiter #(
    parameter int NREQ     = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*7-1:0]  req_cfg,
    input  logic [NREQ*8-1:0]  req_len,
    input  logic [NREQ*16-1:0] req_txd,
    output logic [NREQ-1:0]    txd_pop,
    output logic [15:0]        rxd,
    output logic [NREQ-1:0]    rxd_valid,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    gnt,
    output logic [6:0]         m_cfg,
    output logic [15:0]        m_tx_data,
    output logic               m_tx_valid,
    input  logic               m_tx_ready,
    input  logic [15:0]        m_rx_data,
    output logic [NREQ-1:0]    cs_n
);

    localparam int OW   = $clog2(NREQ);
    localparam int CW   = OW + 1;
    localparam int PMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SETUP,
        ISSUE,
        BUSY,
        DONE_WAIT,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last_owner;
    logic [7:0]      len_q;
    logic [8:0]      frame_cnt;
    logic [PW-1:0]   phase_cnt;

    logic [6:0]      cfg_arr [NREQ];
    logic [7:0]      len_arr [NREQ];
    logic [15:0]     txd_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign cfg_arr[i] = req_cfg[i*7 +: 7];
        assign len_arr[i] = req_len[i*8 +: 8];
        assign txd_arr[i] = req_txd[i*16 +: 16];
    end

    // Rotate req so the search begins just after the previous owner.
    logic [OW-1:0]   start;
    logic [OW-1:0]   off;
    logic [CW-1:0]   sum;
    logic [OW-1:0]   pick;
    logic            found;
    logic [NREQ-1:0] req_rot;

    always_comb begin
        start   = (last_owner == OW'(NREQ - 1)) ? '0 : last_owner + OW'(1);
        req_rot = NREQ'({req, req} >> start);
        found   = 1'b0;
        off     = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                found = 1'b1;
                off   = OW'(j);
            end
        end
        sum  = {1'b0, start} + {1'b0, off};
        pick = (sum >= CW'(NREQ)) ? OW'(sum - CW'(NREQ)) : OW'(sum);
    end

    logic            active;
    logic [NREQ-1:0] owner_oh;
    logic            setup_end;
    logic            hold_end;
    logic            last_frame;

    assign owner_oh   = NREQ'(1) << owner;
    assign active     = (state == SETUP) || (state == ISSUE) || (state == BUSY) ||
                        (state == DONE_WAIT) || (state == HOLD);
    assign setup_end  = (phase_cnt == PW'(CS_SETUP - 1));
    assign hold_end   = (phase_cnt == PW'(CS_HOLD - 1));
    assign last_frame = (frame_cnt == {1'b0, len_q});

    // Select lines decode straight from the state register so reset releases them at once.
    assign gnt        = active ? owner_oh : '0;
    assign cs_n       = ~gnt;
    assign m_tx_valid = (state == ISSUE);
    assign txd_pop    = m_tx_valid ? owner_oh : '0;
    assign m_tx_data  = m_tx_valid ? txd_arr[owner] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if ((|req) && m_tx_ready) state_nxt = ARB;
            ARB:       state_nxt = found ? SETUP : IDLE;
            SETUP:     if (setup_end) state_nxt = ISSUE;
            ISSUE:     state_nxt = BUSY;
            BUSY:      if (!m_tx_ready) state_nxt = DONE_WAIT;
            DONE_WAIT: if (m_tx_ready) state_nxt = last_frame ? HOLD : ISSUE;
            HOLD:      if (hold_end) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            m_cfg      <= '0;
            len_q      <= '0;
            frame_cnt  <= '0;
            phase_cnt  <= '0;
            rxd        <= '0;
            rxd_valid  <= '0;
            done       <= '0;
        end else begin
            rxd_valid <= '0;
            done      <= '0;
            case (state)
                ARB: begin
                    if (found) begin
                        owner     <= pick;
                        m_cfg     <= cfg_arr[pick];
                        len_q     <= len_arr[pick];
                        frame_cnt <= '0;
                        phase_cnt <= '0;
                    end
                end
                SETUP: phase_cnt <= setup_end ? '0 : phase_cnt + PW'(1);
                DONE_WAIT: begin
                    if (m_tx_ready) begin
                        rxd       <= m_rx_data;
                        rxd_valid <= owner_oh;
                        if (!last_frame) frame_cnt <= frame_cnt + 9'd1;
                    end
                end
                HOLD: begin
                    if (hold_end) begin
                        phase_cnt  <= '0;
                        done       <= owner_oh;
                        last_owner <= owner;
                    end else begin
                        phase_cnt <= phase_cnt + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter CS_SETUP, default 2: clk cycles from CS assert to first frame issue (>=1).
REQ-003 Parameter CS_HOLD, default 2: clk cycles from last frame done to CS deassert (>=1).
REQ-004 clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 req  in  NREQ  per-requester transaction request, level.
REQ-006 req_cfg  in  NREQ*7  per-requester {CPOL,CPHA,BR[2:0],DFF,LSBFIRST}.
REQ-007 req_len  in  NREQ*8  per-requester frame count minus one (0 = 1 frame, 255 = 256 frames).
REQ-008 req_txd  in  NREQ*16  per-requester next TX frame.
REQ-009 txd_pop  out  NREQ  1-cycle pulse: granted requester's req_txd consumed; present next frame by the following cycle.
REQ-010 rxd  out  16  last received frame, shared.
REQ-011 rxd_valid  out  NREQ  1-cycle pulse to the owner when rxd updates.
REQ-012 done  out  NREQ  1-cycle pulse to the owner at the end of its transaction.
REQ-013 gnt  out  NREQ  one-hot current owner, SETUP through HOLD.
REQ-014 m_cfg  out  7  config to SPI master; m_tx_data out 16; m_tx_valid out 1; m_tx_ready in 1; m_rx_data in 16.
REQ-015 cs_n  out  NREQ  active-low per-requester chip selects.

Function
REQ-016 States: IDLE, ARB, SETUP, ISSUE, BUSY, DONE_WAIT, HOLD.
REQ-017 IDLE: if any req bit is 1 and m_tx_ready = 1 -> ARB.
REQ-018 ARB (1 cycle): round-robin grant, search starting at last_owner+1 modulo NREQ; latch owner, cfg and len; drive m_cfg; -> SETUP.
REQ-019 last_owner resets to NREQ-1, so requester 0 wins first after reset.
REQ-020 m_cfg changes only in ARB and holds stable until the next ARB.
REQ-021 SETUP: assert cs_n[owner] = 0, set gnt; count CS_SETUP cycles; -> ISSUE.
REQ-022 ISSUE (1 cycle): m_tx_valid = 1, m_tx_data = req_txd[owner]; pulse txd_pop[owner]; -> BUSY.
REQ-023 BUSY: wait for m_tx_ready = 0; -> DONE_WAIT.
REQ-024 DONE_WAIT: on m_tx_ready = 1, capture m_rx_data into rxd and pulse rxd_valid[owner] the next cycle; if the frame counter equals len -> HOLD, else increment the counter -> ISSUE.
REQ-025 m_rx_valid from the master is not used; frame completion is detected only by m_tx_ready returning high.
REQ-026 HOLD: count CS_HOLD cycles, then deassert cs_n, clear gnt, pulse done[owner], set last_owner = owner; -> IDLE.
REQ-027 Back-to-back transactions keep cs_n high for at least 2 cycles (HOLD exit -> IDLE -> ARB).
REQ-028 Deassertion of req during a transaction is ignored; the transaction completes to len+1 frames.
REQ-029 At most one cs_n bit is low at any time; cs_n is low only in SETUP through HOLD.
REQ-030 m_tx_valid is high only in ISSUE, for exactly 1 cycle per frame.
REQ-031 Frame counter is 9 bits wide, with no wrap for len = 255.
REQ-032 req_cfg/req_len changes after ARB have no effect on the current transaction.

Reset
REQ-033 On rst: state IDLE, cs_n all 1, gnt 0, m_tx_valid 0, m_tx_data 0, m_cfg 0, rxd 0, rxd_valid/txd_pop/done 0, counters 0, last_owner NREQ-1.
REQ-034 rst mid-transaction aborts immediately with no done pulse; cs_n goes high asynchronously.

Verification
REQ-035 Single request: req=0001, len=0, txd=A5A5, slave returns 3C3C -> exactly one m_tx_valid; rxd=3C3C with rxd_valid[0]; done[0]; cs_n[0] low >= CS_SETUP + frame + CS_HOLD cycles.
REQ-036 Multi-frame: req=0010, len=3 -> four txd_pop[1] and four rxd_valid[1] pulses; cs_n[1] stays low continuously; one done[1].
REQ-037 Round-robin: req=1111 held -> grant order 0,1,2,3,0; no two cs_n bits low together.
REQ-038 Config isolation: requester 2 cfg=CPOL1/BR=3, requester 3 cfg=CPOL0/BR=0, both requesting -> m_cfg changes only in ARB cycles and matches each owner.
REQ-039 Mid-transaction rst: rst asserted during BUSY of requester 1 -> cs_n=1111 immediately; no done; req=0010 after release restarts cleanly from requester 0's round-robin position.
REQ-040 Max length: len=255 -> 256 frames, then done, with no counter wrap.
